// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Sequences the UART transmit path. A frame is HDR, then four bytes per
//   signed 21-bit result word (6-bit payload each), then TRL. A single-byte
//   status requester is served only between frames.
//
//   Optional feature: define TX_CHECKSUM_EN to insert a mod-64 checksum byte
//   of all data-byte payloads between the last word and TRL.
//
// Ports
//   clk25, reset          : clock (rising edge), async active-high reset
//   frame_start           : one-cycle frame request, sampled in IDLE only
//   base_addr, word_count : frame parameters, latched with frame_start
//   rd_en, rd_addr        : result memory read strobe / address
//   rd_data               : signed word, valid one cycle after rd_en
//   stat_req, stat_byte   : status byte request, last request wins
//   tx_start, tx_data     : byte strobe / byte to async_transmitter
//   tx_busy               : transmitter busy
//   busy, done, sat       : frame in progress, trailer issued, saturation seen
//   state_dbg             : current FSM state encoding
//
// Handshake: a byte is handed over on the cycle tx_start is high. tx_start is
// raised only when the FSM holds a byte, tx_busy is low and tx_start was low
// on the previous cycle; the byte state holds until that happens.
module uart_tx_scheduler #(
    parameter int         ADDR_W = 10,
    parameter logic [7:0] HDR    = 8'd255,
    parameter logic [7:0] TRL    = 8'd191
) (
    input  logic              clk25,
    input  logic              reset,
    input  logic              frame_start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [20:0]       rd_data,
    input  logic              stat_req,
    input  logic [7:0]        stat_byte,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    output logic              busy,
    output logic              done,
    output logic              sat,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_FETCH = 3'd2,
        S_CAPT  = 3'd3,
        S_SEND  = 3'd4,
        S_TRL   = 3'd5,
        S_STAT  = 3'd6
`ifdef TX_CHECKSUM_EN
        , S_CSUM = 3'd7
`endif
    } state_t;

`ifdef TX_CHECKSUM_EN
    localparam state_t AFTER_DATA = S_CSUM;
`else
    localparam state_t AFTER_DATA = S_TRL;
`endif

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr_q, cnt_q;
    logic [1:0]        idx_q;
    logic [19:0]       mag_q;
    logic              sign_q, sat_q, pend_q, tx_start_q;
    logic [7:0]        stat_q;
    logic              byte_state;
    logic [7:0]        data_byte;
    logic [19:0]       neg_lo, mag_nx;
    logic              sat_nx;
`ifdef TX_CHECKSUM_EN
    logic [5:0]        sum_q;
`endif

    // Magnitude of a negative word: |v| < 2^20 except for the most negative
    // value, so the two's complement of the low 20 bits is exact.
    always_comb begin
        neg_lo = ~rd_data[19:0] + 20'd1;
        sat_nx = (rd_data == 21'h100000);
        if (sat_nx)
            mag_nx = 20'hFFFFF;
        else if (rd_data[20])
            mag_nx = neg_lo;
        else
            mag_nx = rd_data[19:0];
    end

    // State register
    always_ff @(posedge clk25 or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (frame_start)
                    state_nx = S_HDR;
                else if (pend_q)
                    state_nx = S_STAT;
            end
            S_HDR:   if (tx_start) state_nx = (cnt_q != '0) ? S_FETCH : AFTER_DATA;
            S_FETCH: state_nx = S_CAPT;
            S_CAPT:  state_nx = S_SEND;
            S_SEND: begin
                if (tx_start && idx_q == 2'd3)
                    state_nx = (cnt_q != ONE) ? S_FETCH : AFTER_DATA;
            end
`ifdef TX_CHECKSUM_EN
            S_CSUM:  if (tx_start) state_nx = S_TRL;
`endif
            S_TRL:   if (tx_start) state_nx = S_IDLE;
            S_STAT:  if (tx_start) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        byte_state = 1'b0;
        data_byte  = 8'd0;
        rd_en      = 1'b0;
        busy       = 1'b0;
        case (state)
            S_HDR: begin
                byte_state = 1'b1;
                data_byte  = HDR;
                busy       = 1'b1;
            end
            S_FETCH: begin
                rd_en = 1'b1;
                busy  = 1'b1;
            end
            S_CAPT: busy = 1'b1;
            S_SEND: begin
                byte_state = 1'b1;
                busy       = 1'b1;
                case (idx_q)
                    2'd0:    data_byte = {2'b00, mag_q[5:0]};
                    2'd1:    data_byte = {2'b00, mag_q[11:6]};
                    2'd2:    data_byte = {2'b00, mag_q[17:12]};
                    default: data_byte = {4'b0000, sign_q, 1'b0, mag_q[19:18]};
                endcase
            end
`ifdef TX_CHECKSUM_EN
            S_CSUM: begin
                byte_state = 1'b1;
                data_byte  = {2'b00, sum_q};
                busy       = 1'b1;
            end
`endif
            S_TRL: begin
                byte_state = 1'b1;
                data_byte  = TRL;
                busy       = 1'b1;
            end
            S_STAT: begin
                byte_state = 1'b1;
                data_byte  = stat_q;
            end
            default: ;
        endcase
        tx_start  = byte_state & ~tx_busy & ~tx_start_q;
        tx_data   = data_byte;
        done      = tx_start & (state == S_TRL);
        sat       = sat_q;
        rd_addr   = addr_q;
        state_dbg = state;
    end

    // Datapath registers
    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            cnt_q      <= '0;
            idx_q      <= 2'd0;
            mag_q      <= 20'd0;
            sign_q     <= 1'b0;
            sat_q      <= 1'b0;
            pend_q     <= 1'b0;
            stat_q     <= 8'd0;
            tx_start_q <= 1'b0;
`ifdef TX_CHECKSUM_EN
            sum_q      <= 6'd0;
`endif
        end else begin
            tx_start_q <= tx_start;
            if (state == S_IDLE && frame_start) begin
                addr_q <= base_addr;
                cnt_q  <= word_count;
                sat_q  <= 1'b0;
                idx_q  <= 2'd0;
`ifdef TX_CHECKSUM_EN
                sum_q  <= 6'd0;
`endif
            end
            if (state == S_CAPT) begin
                mag_q  <= mag_nx;
                sign_q <= rd_data[20];
                if (sat_nx)
                    sat_q <= 1'b1;
            end
            if (state == S_SEND && tx_start) begin
                idx_q <= idx_q + 2'd1;
`ifdef TX_CHECKSUM_EN
                sum_q <= sum_q + data_byte[5:0];
`endif
                if (idx_q == 2'd3) begin
                    addr_q <= addr_q + ONE;
                    cnt_q  <= cnt_q - ONE;
                end
            end
            // A new request on the issue cycle keeps the pending flag set.
            if (stat_req) begin
                pend_q <= 1'b1;
                stat_q <= stat_byte;
            end else if (state == S_STAT && tx_start) begin
                pend_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
module tb_uart_tx_scheduler;

  logic        clk25 = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [9:0]  word_count = '0;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [20:0] rd_data = '0;
  logic        stat_req = 1'b0;
  logic [7:0]  stat_byte = '0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        busy, done, sat;
  logic [2:0]  state_dbg;

  logic [7:0]         exp_q[$];
  logic signed [20:0] mem [0:1023];
  int checks = 0;
  int failures = 0;
  int busy_hold = 0;
  int busy_cnt = 0;
  int cyc = 0;
  int last_cyc = 0;
  bit have_last = 1'b0;
  int rd_cnt = 0;
  int done_cnt = 0;

  uart_tx_scheduler #(.ADDR_W(10), .HDR(8'd255), .TRL(8'd191)) dut (
    .clk25(clk25), .reset(reset), .frame_start(frame_start),
    .base_addr(base_addr), .word_count(word_count),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .stat_req(stat_req), .stat_byte(stat_byte),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .busy(busy), .done(done), .sat(sat), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk25 = ~clk25;

  // result memory: data one cycle after rd_en
  always @(posedge clk25) if (rd_en) rd_data <= mem[rd_addr];

  // transmitter model: busy for busy_hold cycles after each tx_start
  always @(posedge clk25) begin
    if (tx_start) busy_cnt <= busy_hold;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // scoreboard: compare each issued byte with the expected queue
  always @(negedge clk25) begin
    if (!reset) begin
      cyc++;
      if (rd_en) rd_cnt++;
      if (tx_start) begin
        check("tx_not_while_busy", tx_busy, 1'b0);
        if (have_last) check("tx_spacing_ge2", 32'((cyc - last_cyc) >= 2), 1);
        last_cyc = cyc;
        have_last = 1'b1;
        if (exp_q.size() == 0) check("tx_extra_byte", {24'd0, tx_data} + 32'd1000, 0);
        else check("tx_byte", tx_data, exp_q.pop_front());
        if (done) check("done_on_trailer", tx_data, 8'd191);
      end
      if (done) begin
        done_cnt++;
        check("done_with_tx_start", tx_start, 1'b1);
      end
    end
  end

  // expected byte stream for a frame, from the current memory contents
  task automatic push_frame(input int base, input int cnt);
    int a, v, m, sum;
    int b[4];
    sum = 0;
    a = base;
    exp_q.push_back(8'd255);
    for (int w = 0; w < cnt; w++) begin
      v = mem[a];
      m = (v < 0) ? -v : v;
      if (m > 1048575) m = 1048575;
      b[0] = m % 64;
      b[1] = (m / 64) % 64;
      b[2] = (m / 4096) % 64;
      b[3] = ((v < 0) ? 8 : 0) + m / 262144;
      for (int k = 0; k < 4; k++) begin
        exp_q.push_back(8'(b[k]));
        sum += b[k];
      end
      a = (a + 1) % 1024;
    end
`ifdef TX_CHECKSUM_EN
    exp_q.push_back(8'(sum % 64));
`endif
    exp_q.push_back(8'd191);
  endtask

  // drive frame_start for one cycle; called at a negedge
  task automatic start_frame(input int base, input int cnt);
    push_frame(base, cnt);
    frame_start = 1'b1;
    base_addr = 10'(base);
    word_count = 10'(cnt);
    @(negedge clk25);
    frame_start = 1'b0;
    check("busy_at_t1", busy, 1'b1);
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < limit) begin
      @(negedge clk25);
      #1;
      n++;
    end
    if (n >= limit) check("wait_idle_timeout", n, 0);
  endtask

  task automatic pulse_stat(input logic [7:0] val);
    stat_req = 1'b1;
    stat_byte = val;
    @(negedge clk25);
    stat_req = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tx_start"}, tx_start, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_sat"}, sat, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
  endtask

  initial begin
    int r0, d0, seen;
    for (int i = 0; i < 1024; i++) mem[i] = 21'($urandom_range(0, 2097151));
    mem[5] = -21'sd100;
    mem[10] = -21'sd1048576;
    mem[1023] = 21'sd1048575;
    mem[0] = -21'sd1;

    // reset state
    repeat (3) @(negedge clk25);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk25);
    check_all_zero("post_reset");

    // single word -100: 255 36 1 0 8 191
    r0 = rd_cnt; d0 = done_cnt;
    start_frame(5, 1);
    wait_idle(200);
    check("w1_done_cnt", done_cnt - d0, 1);
    check("w1_rd_cnt", rd_cnt - r0, 1);
    check("w1_sat", sat, 0);
    check("w1_busy_after", busy, 0);

    // empty frame
    r0 = rd_cnt; d0 = done_cnt;
    start_frame(7, 0);
    wait_idle(200);
    check("c0_rd_cnt", rd_cnt - r0, 0);
    check("c0_done_cnt", done_cnt - d0, 1);

    // saturating word, sat sticky then cleared on accept
    start_frame(10, 1);
    wait_idle(200);
    check("sat_set", sat, 1);
    start_frame(1023, 2);
    check("sat_cleared", sat, 0);
    wait_idle(200);
    check("wrap_sat", sat, 0);

    // status requests during a slow frame: only the last one, after 191
    busy_hold = 40;
    repeat (45) @(negedge clk25);
    start_frame(5, 1);
    repeat (10) @(negedge clk25);
    pulse_stat(8'hA5);
    repeat (50) @(negedge clk25);
    pulse_stat(8'h5A);
    exp_q.push_back(8'h5A);
    wait_idle(2000);
    repeat (100) @(negedge clk25);
    check("stat_q_empty", exp_q.size(), 0);

    // three random words with a slow transmitter
    d0 = done_cnt;
    start_frame(20, 3);
    wait_idle(3000);
    check("slow_done_cnt", done_cnt - d0, 1);
    repeat (45) @(negedge clk25);

    // reset during SEND of word 2
    busy_hold = 0;
    start_frame(30, 3);
    seen = 0;
    for (int i = 0; i < 200 && seen < 2; i++) begin
      @(negedge clk25);
      if (rd_en) seen++;
    end
    check("rst_saw_fetch2", seen, 2);
    repeat (3) @(negedge clk25);
    check("rst_in_send", state_dbg, 3'd4);
    reset = 1'b1;
    #1;
    check_all_zero("async_rst");
    exp_q.delete();
    @(negedge clk25);
    reset = 1'b0;
    @(negedge clk25);
    d0 = done_cnt;
    start_frame(5, 1);
    wait_idle(200);
    check("after_rst_done_cnt", done_cnt - d0, 1);
    repeat (10) @(negedge clk25);
    check("final_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
